// File: rtl/fifo_pkg.sv
// Shared Gray/binary conversion helpers for the asyncFIFO pointer logic.
// Functions work on a fixed maximum width; callers zero-extend and cast back.
package fifo_pkg;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits contribute nothing to the prefix XOR, so narrow inputs convert correctly.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_counter_sync2.sv
// Two-flop synchronizer bringing a Gray-coded bus into the local clock domain.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gray_ptr_counter.sv
// Write-side pointer for asyncFIFO: binary/Gray write pointer, registered full
// flag against the synchronized read pointer, and write-side occupancy.
module gray_ptr_counter
    import fifo_pkg::*;
#(
    parameter  int ADDR_W = 4,
    localparam int PTR_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic [PTR_W-1:0]  rgray_async,
    output logic [ADDR_W-1:0] waddr,
    output logic [PTR_W-1:0]  wgray,
    output logic              full,
    output logic [PTR_W-1:0]  wlevel
);

    // Full when the write pointer equals the read pointer with its top two Gray bits inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rgray_s;
    logic [PTR_W-1:0] rbin_s;
    logic             accept;
    logic             full_next;

    sync2 #(.W(PTR_W)) u_rsync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rgray_async),
        .q     (rgray_s)
    );

    assign accept     = inc & ~full;
    assign wbin_next  = accept ? wbin + PTR_W'(1) : wbin;
    assign wgray_next = PTR_W'(bin2gray(MAX_W'(wbin_next)));
    assign full_next  = (wgray_next == (rgray_s ^ FULL_MASK));
    assign rbin_s     = PTR_W'(gray2bin(MAX_W'(rgray_s)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin  <= '0;
            wgray <= '0;
            full  <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wgray <= wgray_next;
            full  <= full_next;
        end
    end

    assign waddr  = wbin[ADDR_W-1:0];
    assign wlevel = wbin - rbin_s;

endmodule

// File: doc/gray_ptr_counter.md
GRAY_PTR_COUNTER -- requirements
Module: gray_ptr_counter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, FIFO address width (depth = 2**ADDR_W); ADDR_W >= 1.
REQ-002 SHALL have derived localparam PTR_W = ADDR_W+1, the pointer width including the wrap bit.
REQ-003 SHALL have port clk  input  1  the single write-domain clock; all flops rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port inc  input  1  push request from the write side.
REQ-006 SHALL have port rgray_async  input  PTR_W  Gray-coded read pointer from the read clock domain, unsynchronized.
REQ-007 SHALL have port waddr  output  ADDR_W  RAM write address, equal to wbin[ADDR_W-1:0].
REQ-008 SHALL have port wgray  output  PTR_W  registered Gray write pointer for export to the read domain.
REQ-009 SHALL have port full  output  1  registered full flag.
REQ-010 SHALL have port wlevel  output  PTR_W  occupancy as seen by the write side, 0..2**ADDR_W.

Function
REQ-011 SHALL keep internal registers wbin (binary, PTR_W) and wgray; wgray SHALL always equal wbin ^ (wbin >> 1).
REQ-012 SHALL define accept = inc & ~full; on each clk edge with accept=1, wbin <= wbin+1 mod 2**PTR_W.
REQ-013 SHALL hold wbin, wgray and waddr unchanged on edges where accept=0, including inc=1 while full=1, with no error indication.
REQ-014 SHALL compute the next Gray value from the next binary value and register it directly, so no combinational logic drives wgray; consecutive wgray values differ in exactly one bit, including at the 2**PTR_W-1 -> 0 wrap.
REQ-015 SHALL synchronize rgray_async through a 2-flop synchronizer into rgray_s.
REQ-016 SHALL register full_next = (wgray_next == {~rgray_s[PTR_W-1:PTR_W-2], rgray_s[PTR_W-3:0]}).
- For ADDR_W=1 the low field is empty.
REQ-017 SHALL produce wlevel = (wbin - rbin_s) mod 2**PTR_W, with rbin_s the Gray-to-binary conversion of rgray_s (bit i = XOR of rgray_s bits i..PTR_W-1); wlevel is combinational from registers.
REQ-018 SHALL make a change on rgray_async affect full at the 3rd rising clk edge after the change (2 sync stages + flag register) and affect wlevel after the 2nd.
REQ-019 SHALL make full pessimistic: it may remain 1 while the read pointer is in flight, but SHALL never be 0 when 2**ADDR_W entries are written and unread.
REQ-020 SHALL, on a push and a full-clearing read pointer arriving on the same edge, evaluate the push against the registered full of that cycle (push rejected), and SHALL clear full on that edge.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously force wbin=0, wgray=0, both synchronizer stages=0 and full=0, giving waddr=0 and wlevel=0.
REQ-022 SHALL, on reset assertion mid-operation, discard in-progress pushes; the first accept after deassertion writes waddr=0.
REQ-023 SHALL deassert rst_n externally synchronized to clk; the block SHALL NOT include a reset synchronizer.

Structure
REQ-024 SHALL place a shared package fifo_pkg with functions bin2gray and gray2bin (width-generic via parameterized class or fixed max width) and no typedefs beyond these.
REQ-025 SHALL instantiate one sub-module sync2 (parameter W, 2-flop synchronizer, async active-low reset to 0) for rgray_async.
REQ-026 SHALL serve as the write-side pointer for asyncFIFO; a mirrored read-side block is out of scope.

Verification (ADDR_W=2, depth 4, PTR_W=3)
REQ-027 SHALL check reset: rst_n=0 with inc=1 and rgray_async=3'b101 -> waddr=0, wgray=0, full=0, wlevel=0.
REQ-028 SHALL check the fill sequence: rgray_async=0 held, inc=1 for 5 edges -> wgray 1,3,2,6 then held at 6; full=1 after the 4th edge; 5th push rejected; wlevel=4.
REQ-029 SHALL check drain latency: from full, rgray_async=3'b001 -> full=1 through 2 edges, full=0 after the 3rd edge; wlevel=3 after the 2nd edge.
REQ-030 SHALL check wrap: with rgray_async tracking wgray delayed 1 cycle, 10 pushes -> wbin wraps 7->0 with wgray 4->0, single-bit changes checked every edge, full never set.
REQ-031 SHALL check the simultaneous case: full=1, inc=1 and full clearing on the same edge -> wbin unchanged that edge; push accepted on the next edge.
REQ-032 SHALL check mid-operation reset: after 3 pushes, pulse rst_n low for less than one cycle -> all outputs 0 immediately (async); the next push gives waddr=0 then wgray=1.
